// File: rtl/phy_types_pkg.sv
// ============================================================================
//  phy_types_pkg : shared comma-class type and class-index constants
//  Revision      : 1.0
// ============================================================================
`default_nettype none

package phy_types_pkg;

  typedef enum logic [2:0] {
    COMMA_NONE = 3'd0,
    ACK        = 3'd1,
    NACK       = 3'd2,
    RS0        = 3'd3,
    RS1        = 3'd4,
    RS2        = 3'd5,
    RS3        = 3'd6,
    DATA       = 3'd7
  } comma_sel_t;

  localparam int NUM_CLASSES = 7;

  // Index order doubles as grant priority (lowest index wins)
  localparam logic [2:0] IDX_ACK  = 3'd0;
  localparam logic [2:0] IDX_NACK = 3'd1;
  localparam logic [2:0] IDX_RS0  = 3'd2;
  localparam logic [2:0] IDX_RS1  = 3'd3;
  localparam logic [2:0] IDX_RS2  = 3'd4;
  localparam logic [2:0] IDX_RS3  = 3'd5;
  localparam logic [2:0] IDX_DATA = 3'd6;

  function automatic comma_sel_t idx_to_sel(input logic [2:0] idx);
    return comma_sel_t'(idx + 3'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_comma_scheduler_sat_req_counter.sv
// ============================================================================
//  sat_req_counter : saturating pending-request counter (drops inc when full)
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module sat_req_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             full
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             inc_eff;

  always_comb begin
    inc_eff = inc && (count_q != MAX_COUNT);
    count_d = count_q;
    if (inc_eff && !dec) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc_eff && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == MAX_COUNT);

endmodule

`default_nettype wire

// File: rtl/tx_comma_scheduler.sv
// ============================================================================
//  tx_comma_scheduler : priority scheduler granting queued commas / data packets
//  Optional macro     : TX_SCHED_AGING_EN (forces a data grant after AGE_LIMIT
//                       consecutive comma grants while data is pending)
//  Revision           : 1.0
// ============================================================================
`default_nettype none

module tx_comma_scheduler
  import phy_types_pkg::*;
#(
  parameter int COUNTER_SIZE = 4,
  parameter int AGE_LIMIT    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ack_write,
  input  logic       nack_write,
  input  logic [3:0] rs_write,
  input  logic       data_write,
  input  logic [7:0] rx_header,
  input  logic       done,
  input  logic       packet_done,
  output logic [6:0] cnt_full,
  output logic       start,
  output logic       get_data,
  output comma_sel_t comma_sel,
  output logic [7:0] comma_header_out
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_WAIT_PKT  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  comma_sel_t              sel_q, sel_d;
  logic [7:0]              hdr_smp_q, hdr_smp_d;
  logic [7:0]              hdr_out_q, hdr_out_d;
  logic [NUM_CLASSES-1:0]  wr;
  logic [NUM_CLASSES-1:0]  dec;
  logic [NUM_CLASSES-1:0]  pend;
  logic [NUM_CLASSES-1:0]  full;
  logic [COUNTER_SIZE-1:0] cnt [NUM_CLASSES];
  logic                    grant_vld;
  logic [2:0]              grant_idx;

  assign wr = {data_write, rs_write, nack_write, ack_write};

  generate
    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
      sat_req_counter #(
        .WIDTH (COUNTER_SIZE)
      ) u_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (wr[i]),
        .dec   (dec[i]),
        .count (cnt[i]),
        .full  (full[i])
      );
      assign pend[i] = |cnt[i];
    end
  endgenerate

`ifdef TX_SCHED_AGING_EN
  localparam int AGE_W = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] age_q, age_d;
  logic             age_expired;

  assign age_expired = (age_q >= AGE_W'(AGE_LIMIT));

  // Age tracks comma grants that bypassed waiting data; a data grant resets it
  always_comb begin
    age_d = age_q;
    if ((state_q == ST_IDLE) && grant_vld) begin
      if (grant_idx == IDX_DATA) begin
        age_d = '0;
      end else if (pend[IDX_DATA] && !age_expired) begin
        age_d = age_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

  always_comb begin
    grant_vld = |pend;
    grant_idx = IDX_DATA;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (pend[i]) begin
        grant_idx = 3'(i);
      end
    end
`ifdef TX_SCHED_AGING_EN
    if (age_expired && pend[IDX_DATA]) begin
      grant_idx = IDX_DATA;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hdr_smp_d = hdr_smp_q;
    hdr_out_d = hdr_out_q;
    dec       = '0;
    if (ack_write || nack_write) begin
      hdr_smp_d = rx_header;
    end
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          dec     = {{(NUM_CLASSES - 1){1'b0}}, 1'b1} << grant_idx;
          sel_d   = idx_to_sel(grant_idx);
          state_d = ST_START;
          // Same-cycle header write is the latest one and must win
          if ((grant_idx == IDX_ACK) || (grant_idx == IDX_NACK)) begin
            hdr_out_d = hdr_smp_d;
          end
        end
      end
      ST_START: begin
        state_d = (sel_q == DATA) ? ST_WAIT_PKT : ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done) begin
          state_d = ST_IDLE;
          sel_d   = COMMA_NONE;
        end
      end
      ST_WAIT_PKT: begin
        if (packet_done) begin
          state_d = ST_IDLE;
          sel_d   = COMMA_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = COMMA_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      sel_q     <= COMMA_NONE;
      hdr_smp_q <= 8'h00;
      hdr_out_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      hdr_smp_q <= hdr_smp_d;
      hdr_out_q <= hdr_out_d;
    end
  end

  assign start            = (state_q == ST_START);
  assign get_data         = (state_q == ST_START) && (sel_q == DATA);
  assign comma_sel        = sel_q;
  assign comma_header_out = hdr_out_q;
  assign cnt_full         = full;

endmodule

`default_nettype wire

// File: tb/tb_tx_comma_scheduler.sv
// ============================================================================
//  tb_tx_comma_scheduler : directed scenarios plus random traffic vs a
//                          transaction-level scheduler model
//  Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_tx_comma_scheduler;
  import phy_types_pkg::*;

  localparam int CSZ  = 4;
  localparam int CMAX = (1 << CSZ) - 1;
`ifdef TX_SCHED_AGING_EN
  localparam int AGE_LIM  = 2;
  localparam bit AGING_ON = 1'b1;
`else
  localparam int AGE_LIM  = 8;
  localparam bit AGING_ON = 1'b0;
`endif
  localparam comma_sel_t CLS_SEL [7] = '{ACK, NACK, RS0, RS1, RS2, RS3, DATA};

  logic       CLK = 1'b0;
  logic       RST;
  logic       ack_write, nack_write, data_write, done, packet_done;
  logic [3:0] rs_write;
  logic [7:0] rx_header;
  logic [6:0] cnt_full;
  logic       start, get_data;
  comma_sel_t comma_sel;
  logic [7:0] comma_header_out;

  int checks = 0;
  int errors = 0;

  // Model: pending counts per class, current grant (-1 = idle), edges since grant
  int         m_cnt [7];
  int         m_cur, m_since, m_age;
  logic [7:0] m_latest, m_hdr;

  tx_comma_scheduler #(
    .COUNTER_SIZE (CSZ),
    .AGE_LIMIT    (AGE_LIM)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .ack_write        (ack_write),
    .nack_write       (nack_write),
    .rs_write         (rs_write),
    .data_write       (data_write),
    .rx_header        (rx_header),
    .done             (done),
    .packet_done      (packet_done),
    .cnt_full         (cnt_full),
    .start            (start),
    .get_data         (get_data),
    .comma_sel        (comma_sel),
    .comma_header_out (comma_header_out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  function automatic comma_sel_t exp_sel();
    return (m_cur < 0) ? COMMA_NONE : CLS_SEL[m_cur];
  endfunction

  function automatic logic exp_start();
    return (m_cur >= 0) && (m_since == 1);
  endfunction

  function automatic logic [6:0] exp_full();
    logic [6:0] f;
    for (int i = 0; i < 7; i++) f[i] = (m_cnt[i] == CMAX);
    return f;
  endfunction

  task automatic clear_inputs();
    ack_write = 0; nack_write = 0; rs_write = 4'h0; data_write = 0;
    rx_header = 8'h00; done = 0; packet_done = 0;
  endtask

  // One clock: inputs are stable, model applies the scheduling rules, then negedge
  task automatic tick();
    int w [7];
    int g;
    bit match;
    w[0] = int'(ack_write);   w[1] = int'(nack_write);
    w[2] = int'(rs_write[0]); w[3] = int'(rs_write[1]);
    w[4] = int'(rs_write[2]); w[5] = int'(rs_write[3]);
    w[6] = int'(data_write);
    @(posedge CLK);
    if (RST) begin
      for (int i = 0; i < 7; i++) m_cnt[i] = 0;
      m_cur = -1; m_since = 0; m_age = 0; m_hdr = 8'h00; m_latest = 8'h00;
    end else begin
      g = -1;
      if (m_cur < 0) begin
        for (int i = 6; i >= 0; i--) if (m_cnt[i] > 0) g = i;
        if (AGING_ON && m_age >= AGE_LIM && m_cnt[6] > 0) g = 6;
      end else begin
        match = (m_cur == 6) ? packet_done : done;
        if (m_since >= 2 && match) m_cur = -1;
        else m_since++;
      end
      if (ack_write || nack_write) m_latest = rx_header;
      if (g == 0 || g == 1) m_hdr = m_latest;
      if (g >= 0) begin
        if (g == 6) m_age = 0;
        else if (m_cnt[6] > 0 && m_age < AGE_LIM) m_age++;
        m_cur = g; m_since = 1;
      end
      for (int i = 0; i < 7; i++)
        m_cnt[i] += ((w[i] != 0 && m_cnt[i] < CMAX) ? 1 : 0) - ((g == i) ? 1 : 0);
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1; tick(); tick(); RST = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1; ack_write = 1; data_write = 1;
    tick(); tick();
    RST = 0; clear_inputs();
    checks++; if (cnt_full !== 7'h00) begin errors++; $display("FAIL reset_full: got %h want 00", cnt_full); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start); end
    checks++; if (get_data !== 1'b0) begin errors++; $display("FAIL reset_get_data: got %b want 0", get_data); end
    checks++; if (comma_sel !== COMMA_NONE) begin errors++; $display("FAIL reset_sel: got %0d want 0", comma_sel); end
    checks++; if (comma_header_out !== 8'h00) begin errors++; $display("FAIL reset_hdr: got %h want 00", comma_header_out); end
    tick(); tick();
    checks++; if (comma_sel !== COMMA_NONE || start !== 1'b0) begin
      errors++; $display("FAIL reset_writes_dropped: sel %0d start %b want 0 0", comma_sel, start);
    end
  endtask

  task automatic test_nack_rs2();
    do_reset();
    nack_write = 1; rs_write = 4'b0100;
    tick();
    clear_inputs();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL nr_start_early: got %b want 0", start); end
    tick();
    checks++; if (start !== 1'b1 || comma_sel !== NACK) begin
      errors++; $display("FAIL nr_nack_grant: start %b sel %0d want 1 %0d", start, comma_sel, NACK);
    end
    tick();
    checks++; if (start !== 1'b0 || comma_sel !== NACK) begin
      errors++; $display("FAIL nr_nack_hold: start %b sel %0d want 0 %0d", start, comma_sel, NACK);
    end
    done = 1; tick(); done = 0;
    checks++; if (comma_sel !== COMMA_NONE) begin errors++; $display("FAIL nr_idle: got %0d want 0", comma_sel); end
    tick();
    checks++; if (start !== 1'b1 || comma_sel !== RS2) begin
      errors++; $display("FAIL nr_rs2_grant: start %b sel %0d want 1 %0d", start, comma_sel, RS2);
    end
  endtask

  task automatic test_saturation();
    int n_ack;
    do_reset();
    data_write = 1; tick(); data_write = 0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      ack_write = 1; tick();
      checks++; if (cnt_full[0] !== (k >= 15)) begin
        errors++; $display("FAIL sat_full_after_%0d: got %b want %b", k, cnt_full[0], (k >= 15));
      end
    end
    ack_write = 0;
    checks++; if (comma_sel !== DATA) begin errors++; $display("FAIL sat_data_hold: got %0d want %0d", comma_sel, DATA); end
    packet_done = 1; tick(); packet_done = 0;
    done = 1; n_ack = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (start && comma_sel == ACK) n_ack++;
    end
    done = 0;
    checks++; if (n_ack != 15) begin errors++; $display("FAIL sat_ack_grants: got %0d want 15", n_ack); end
    checks++; if (cnt_full !== 7'h00 || comma_sel !== COMMA_NONE) begin
      errors++; $display("FAIL sat_drained: full %h sel %0d want 00 0", cnt_full, comma_sel);
    end
  endtask

  task automatic test_data();
    do_reset();
    data_write = 1; tick(); tick(); data_write = 0;
    checks++; if (start !== 1'b1 || get_data !== 1'b1 || comma_sel !== DATA) begin
      errors++; $display("FAIL data_grant1: start %b get %b sel %0d want 1 1 %0d", start, get_data, comma_sel, DATA);
    end
    done = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (comma_sel !== DATA || start !== 1'b0 || get_data !== 1'b0) begin
        errors++; $display("FAIL data_hold_%0d: sel %0d start %b get %b want %0d 0 0", k, comma_sel, start, get_data, DATA);
      end
    end
    done = 0; packet_done = 1; tick(); packet_done = 0;
    checks++; if (comma_sel !== COMMA_NONE) begin errors++; $display("FAIL data_release: got %0d want 0", comma_sel); end
    tick();
    checks++; if (start !== 1'b1 || get_data !== 1'b1 || comma_sel !== DATA) begin
      errors++; $display("FAIL data_grant2: start %b get %b sel %0d want 1 1 %0d", start, get_data, comma_sel, DATA);
    end
  endtask

  task automatic test_header();
    do_reset();
    ack_write = 1; rx_header = 8'hA5; tick(); ack_write = 0;
    nack_write = 1; rx_header = 8'h3C; tick(); clear_inputs();
    checks++; if (comma_sel !== ACK || start !== 1'b1 || comma_header_out !== 8'h3C) begin
      errors++; $display("FAIL hdr_ack: sel %0d start %b hdr %h want %0d 1 3c", comma_sel, start, comma_header_out, ACK);
    end
    done = 1; tick(); tick(); tick(); done = 0;
    checks++; if (comma_sel !== NACK || start !== 1'b1 || comma_header_out !== 8'h3C) begin
      errors++; $display("FAIL hdr_nack: sel %0d start %b hdr %h want %0d 1 3c", comma_sel, start, comma_header_out, NACK);
    end
    do_reset();
    ack_write = 1; nack_write = 1; rx_header = 8'h5A; tick();
    clear_inputs(); rx_header = 8'hFF; tick();
    checks++; if (comma_sel !== ACK || comma_header_out !== 8'h5A) begin
      errors++; $display("FAIL hdr_both_ack: sel %0d hdr %h want %0d 5a", comma_sel, comma_header_out, ACK);
    end
    done = 1; tick(); tick(); tick(); done = 0;
    checks++; if (comma_sel !== NACK || comma_header_out !== 8'h5A) begin
      errors++; $display("FAIL hdr_both_nack: sel %0d hdr %h want %0d 5a", comma_sel, comma_header_out, NACK);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    rs_write = 4'b0001;
    repeat (4) tick();
    rs_write = 4'h0;
    checks++; if (comma_sel !== RS0 || start !== 1'b0) begin
      errors++; $display("FAIL mid_wait: sel %0d start %b want %0d 0", comma_sel, start, RS0);
    end
    RST = 1; tick(); RST = 0;
    checks++; if (comma_sel !== COMMA_NONE || cnt_full !== 7'h00 || start !== 1'b0) begin
      errors++; $display("FAIL mid_reset: sel %0d full %h start %b want 0 00 0", comma_sel, cnt_full, start);
    end
    done = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (start !== 1'b0 || comma_sel !== COMMA_NONE) begin
        errors++; $display("FAIL mid_no_grant_%0d: start %b sel %0d want 0 0", k, start, comma_sel);
      end
    end
    done = 0;
  endtask

  task automatic test_random();
    int hi;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      hi = (c / 750) % 2;
      ack_write   = ($urandom_range(0, 3 - 2 * hi) == 0);
      nack_write  = ($urandom_range(0, 5 - 3 * hi) == 0);
      rs_write    = 4'($urandom) & 4'($urandom) & (hi != 0 ? 4'hF : 4'($urandom));
      data_write  = ($urandom_range(0, 4) == 0);
      rx_header   = 8'($urandom);
      done        = ($urandom_range(0, 2) == 0);
      packet_done = ($urandom_range(0, 2) == 0);
      RST         = ((c % 997) == 996);
      tick();
      checks++; if (comma_sel !== exp_sel()) begin
        errors++; $display("FAIL rnd_sel c=%0d: got %0d want %0d", c, comma_sel, exp_sel());
      end
      checks++; if (start !== exp_start()) begin
        errors++; $display("FAIL rnd_start c=%0d: got %b want %b", c, start, exp_start());
      end
      checks++; if (get_data !== (exp_start() && m_cur == 6)) begin
        errors++; $display("FAIL rnd_get_data c=%0d: got %b want %b", c, get_data, (exp_start() && m_cur == 6));
      end
      checks++; if (cnt_full !== exp_full()) begin
        errors++; $display("FAIL rnd_full c=%0d: got %h want %h", c, cnt_full, exp_full());
      end
      checks++; if (comma_header_out !== m_hdr) begin
        errors++; $display("FAIL rnd_hdr c=%0d: got %h want %h", c, comma_header_out, m_hdr);
      end
    end
    RST = 0; clear_inputs();
  endtask

`ifdef TX_SCHED_AGING_EN
  task automatic test_aging();
    int n_ack;
    bit seen_data;
    do_reset();
    data_write = 1; ack_write = 1; tick(); data_write = 0;
    done = 1; n_ack = 0; seen_data = 0;
    for (int c = 0; c < 40 && !seen_data; c++) begin
      tick();
      if (start && comma_sel == ACK) n_ack++;
      else if (start && comma_sel == DATA) seen_data = 1;
    end
    clear_inputs();
    checks++; if (!seen_data) begin errors++; $display("FAIL age_data_grant: got 0 want 1"); end
    checks++; if (n_ack != AGE_LIM) begin errors++; $display("FAIL age_ack_count: got %0d want %0d", n_ack, AGE_LIM); end
  endtask
`endif

  initial begin
    clear_inputs();
    RST = 1;
    m_cur = -1; m_since = 0; m_age = 0; m_hdr = 8'h00; m_latest = 8'h00;
    for (int i = 0; i < 7; i++) m_cnt[i] = 0;
    @(negedge CLK);
    test_reset();
    test_nack_rs2();
    test_saturation();
    test_data();
    test_header();
    test_reset_mid_grant();
`ifdef TX_SCHED_AGING_EN
    test_aging();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
